// File: rtl/sonar_vector_sequencer.sv
// Multi-channel command sequencer. Each channel runs a stream of delay, signal, wait,
// flag, timestamp and END commands. All active channels meet at an END barrier that
// closes each test vector.
module sonar_vector_sequencer #(
    parameter int unsigned NUM_CHANNELS = 4,
    parameter int unsigned ARG_WIDTH    = 32,
    parameter int unsigned NUM_SIGNALS  = 8,
    parameter int unsigned NUM_FLAGS    = 8,
    parameter int unsigned TS_WIDTH     = 32,
    parameter int unsigned CMD_WIDTH    = ARG_WIDTH + 8
) (
    input  logic                              ap_clk,
    input  logic                              ap_rst_n,
    input  logic [NUM_CHANNELS-1:0]           cmd_valid,
    output logic [NUM_CHANNELS-1:0]           cmd_ready,
    input  logic [NUM_CHANNELS*CMD_WIDTH-1:0] cmd_data,
    input  logic [NUM_CHANNELS-1:0]           active_mask,
    input  logic [NUM_SIGNALS-1:0]            sig_in,
    output logic [NUM_SIGNALS-1:0]            sig_out,
    output logic [NUM_FLAGS-1:0]              flags,
    output logic                              ts_valid,
    output logic [$clog2(NUM_CHANNELS):0]     ts_chan,
    output logic [TS_WIDTH-1:0]               ts_delta,
    output logic                              vector_done,
    output logic [ARG_WIDTH-1:0]              vector_id,
    output logic [31:0]                       vector_count,
    output logic                              err
);

    localparam int unsigned ChanW    = $clog2(NUM_CHANNELS) + 1;
    localparam int unsigned SigIdxW  = (NUM_SIGNALS > 1) ? $clog2(NUM_SIGNALS) : 1;
    localparam int unsigned FlagIdxW = (NUM_FLAGS > 1) ? $clog2(NUM_FLAGS) : 1;

    localparam logic [3:0] OpNop      = 4'd0;
    localparam logic [3:0] OpDelay    = 4'd1;
    localparam logic [3:0] OpSignal   = 4'd2;
    localparam logic [3:0] OpWait     = 4'd3;
    localparam logic [3:0] OpFlagSet  = 4'd4;
    localparam logic [3:0] OpFlagClr  = 4'd5;
    localparam logic [3:0] OpWaitFlag = 4'd6;
    localparam logic [3:0] OpTsInit   = 4'd7;
    localparam logic [3:0] OpTs       = 4'd8;
    localparam logic [3:0] OpEnd      = 4'd9;

    typedef enum logic [2:0] {
        StFetch,
        StDelay,
        StWaitSig,
        StWaitFlag,
        StBarrier
    } chan_state_e;

    chan_state_e          state_q   [NUM_CHANNELS];
    chan_state_e          state_d   [NUM_CHANNELS];
    logic [ARG_WIDTH-1:0] cnt_q     [NUM_CHANNELS];
    logic [ARG_WIDTH-1:0] cnt_d     [NUM_CHANNELS];
    logic [SigIdxW-1:0]   wsel_q    [NUM_CHANNELS];
    logic [SigIdxW-1:0]   wsel_d    [NUM_CHANNELS];
    logic                 wval_q    [NUM_CHANNELS];
    logic                 wval_d    [NUM_CHANNELS];
    logic [FlagIdxW-1:0]  wflag_q   [NUM_CHANNELS];
    logic [FlagIdxW-1:0]  wflag_d   [NUM_CHANNELS];
    logic [ARG_WIDTH-1:0] end_arg_q [NUM_CHANNELS];
    logic [ARG_WIDTH-1:0] end_arg_d [NUM_CHANNELS];

    logic [3:0]           op  [NUM_CHANNELS];
    logic [3:0]           sel [NUM_CHANNELS];
    logic [ARG_WIDTH-1:0] arg [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] ready;
    logic [NUM_CHANNELS-1:0] accept;
    logic                    ts_claimed;

    logic [NUM_SIGNALS-1:0] sig_out_q, sig_out_d;
    logic [NUM_FLAGS-1:0]   flags_q, flags_d;
    logic [TS_WIDTH-1:0]    counter_q;
    logic [TS_WIDTH-1:0]    time_ref_q, time_ref_d;
    logic                   ts_valid_q, ts_valid_d;
    logic [ChanW-1:0]       ts_chan_q, ts_chan_d;
    logic [TS_WIDTH-1:0]    ts_delta_q, ts_delta_d;
    logic                   vector_done_q, vector_done_d;
    logic [ARG_WIDTH-1:0]   vector_id_q, vector_id_d;
    logic [31:0]            vector_count_q, vector_count_d;
    logic                   err_q, err_d;
    logic                   release_ok;
    logic                   sig_ok;
    logic                   flag_ok;

    // Field decode and handshake; only the lowest channel presenting TIMESTAMP gets ready.
    always_comb begin
        ready      = '0;
        accept     = '0;
        ts_claimed = 1'b0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            op[c]    = cmd_data[c*CMD_WIDTH + CMD_WIDTH - 1 -: 4];
            sel[c]   = cmd_data[c*CMD_WIDTH + CMD_WIDTH - 5 -: 4];
            arg[c]   = cmd_data[c*CMD_WIDTH +: ARG_WIDTH];
            ready[c] = ap_rst_n && (state_q[c] == StFetch);
            if (ready[c] && cmd_valid[c] && (op[c] == OpTs)) begin
                if (ts_claimed) begin
                    ready[c] = 1'b0;
                end
                ts_claimed = 1'b1;
            end
            accept[c] = ready[c] & cmd_valid[c];
        end
    end

    // Channel FSM next state, shared register writes and barrier release.
    always_comb begin
        sig_out_d      = sig_out_q;
        flags_d        = flags_q;
        time_ref_d     = time_ref_q;
        err_d          = err_q;
        ts_valid_d     = 1'b0;
        ts_chan_d      = ts_chan_q;
        ts_delta_d     = ts_delta_q;
        vector_done_d  = 1'b0;
        vector_id_d    = vector_id_q;
        vector_count_d = vector_count_q;
        sig_ok         = 1'b0;
        flag_ok        = 1'b0;

        release_ok = |active_mask;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (active_mask[c] && (state_q[c] != StBarrier)) begin
                release_ok = 1'b0;
            end
        end

        // Walk from the highest index down so the lowest channel wins same-bit conflicts.
        for (int c = NUM_CHANNELS - 1; c >= 0; c--) begin
            state_d[c]   = state_q[c];
            cnt_d[c]     = cnt_q[c];
            wsel_d[c]    = wsel_q[c];
            wval_d[c]    = wval_q[c];
            wflag_d[c]   = wflag_q[c];
            end_arg_d[c] = end_arg_q[c];
            sig_ok       = 32'(sel[c]) < NUM_SIGNALS;
            flag_ok      = 64'(arg[c]) < 64'(NUM_FLAGS);
            unique case (state_q[c])
                StFetch: begin
                    if (accept[c]) begin
                        case (op[c])
                            OpNop: ;
                            OpDelay: begin
                                // The accept cycle counts, so arg 0 and 1 never leave FETCH.
                                if (arg[c] > ARG_WIDTH'(1)) begin
                                    state_d[c] = StDelay;
                                    cnt_d[c]   = arg[c] - ARG_WIDTH'(1);
                                end
                            end
                            OpSignal: begin
                                if (sig_ok) sig_out_d[sel[c][SigIdxW-1:0]] = arg[c][0];
                                else        err_d = 1'b1;
                            end
                            OpWait: begin
                                if (sig_ok) begin
                                    state_d[c] = StWaitSig;
                                    wsel_d[c]  = sel[c][SigIdxW-1:0];
                                    wval_d[c]  = arg[c][0];
                                end else begin
                                    err_d = 1'b1;
                                end
                            end
                            OpFlagSet: begin
                                if (flag_ok) flags_d[arg[c][FlagIdxW-1:0]] = 1'b1;
                                else         err_d = 1'b1;
                            end
                            OpFlagClr: begin
                                if (flag_ok) flags_d[arg[c][FlagIdxW-1:0]] = 1'b0;
                                else         err_d = 1'b1;
                            end
                            OpWaitFlag: begin
                                if (flag_ok) begin
                                    state_d[c] = StWaitFlag;
                                    wflag_d[c] = arg[c][FlagIdxW-1:0];
                                end else begin
                                    err_d = 1'b1;
                                end
                            end
                            OpTsInit: time_ref_d = counter_q;
                            OpTs: begin
                                ts_valid_d = 1'b1;
                                ts_chan_d  = ChanW'(c);
                                ts_delta_d = counter_q - time_ref_q;
                            end
                            OpEnd: begin
                                state_d[c]   = StBarrier;
                                end_arg_d[c] = arg[c];
                            end
                            default: err_d = 1'b1;
                        endcase
                    end
                end
                StDelay: begin
                    cnt_d[c] = cnt_q[c] - ARG_WIDTH'(1);
                    if (cnt_q[c] == ARG_WIDTH'(1)) state_d[c] = StFetch;
                end
                StWaitSig: begin
                    if (sig_in[wsel_q[c]] == wval_q[c]) state_d[c] = StFetch;
                end
                StWaitFlag: begin
                    if (flags_q[wflag_q[c]]) state_d[c] = StFetch;
                end
                StBarrier: begin
                    if (release_ok) state_d[c] = StFetch;
                end
                default: state_d[c] = StFetch;
            endcase
        end

        if (release_ok) begin
            vector_done_d  = 1'b1;
            vector_count_d = vector_count_q + 32'd1;
            for (int c = NUM_CHANNELS - 1; c >= 0; c--) begin
                if (active_mask[c]) vector_id_d = end_arg_q[c];
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                state_q[c]   <= StFetch;
                cnt_q[c]     <= '0;
                wsel_q[c]    <= '0;
                wval_q[c]    <= 1'b0;
                wflag_q[c]   <= '0;
                end_arg_q[c] <= '0;
            end
            sig_out_q      <= '0;
            flags_q        <= '0;
            counter_q      <= '0;
            time_ref_q     <= '0;
            ts_valid_q     <= 1'b0;
            ts_chan_q      <= '0;
            ts_delta_q     <= '0;
            vector_done_q  <= 1'b0;
            vector_id_q    <= '0;
            vector_count_q <= '0;
            err_q          <= 1'b0;
        end else begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                state_q[c]   <= state_d[c];
                cnt_q[c]     <= cnt_d[c];
                wsel_q[c]    <= wsel_d[c];
                wval_q[c]    <= wval_d[c];
                wflag_q[c]   <= wflag_d[c];
                end_arg_q[c] <= end_arg_d[c];
            end
            sig_out_q      <= sig_out_d;
            flags_q        <= flags_d;
            counter_q      <= counter_q + TS_WIDTH'(1);
            time_ref_q     <= time_ref_d;
            ts_valid_q     <= ts_valid_d;
            ts_chan_q      <= ts_chan_d;
            ts_delta_q     <= ts_delta_d;
            vector_done_q  <= vector_done_d;
            vector_id_q    <= vector_id_d;
            vector_count_q <= vector_count_d;
            err_q          <= err_d;
        end
    end

    assign cmd_ready    = ready;
    assign sig_out      = sig_out_q;
    assign flags        = flags_q;
    assign ts_valid     = ts_valid_q;
    assign ts_chan      = ts_chan_q;
    assign ts_delta     = ts_delta_q;
    assign vector_done  = vector_done_q;
    assign vector_id    = vector_id_q;
    assign vector_count = vector_count_q;
    assign err          = err_q;

endmodule

// File: tb/tb_sonar_vector_sequencer.sv
// Directed bench for sonar_vector_sequencer: single-cycle op table on ch0, then
// multi-cycle sequences for delay, barrier, flag handshake, timestamps and reset.
module tb_sonar_vector_sequencer;

    localparam int NCH = 4;
    localparam int CW  = 40;

    localparam logic [3:0] OpNop      = 4'd0;
    localparam logic [3:0] OpDelay    = 4'd1;
    localparam logic [3:0] OpSignal   = 4'd2;
    localparam logic [3:0] OpWait     = 4'd3;
    localparam logic [3:0] OpFlagSet  = 4'd4;
    localparam logic [3:0] OpFlagClr  = 4'd5;
    localparam logic [3:0] OpWaitFlag = 4'd6;
    localparam logic [3:0] OpTsInit   = 4'd7;
    localparam logic [3:0] OpTs       = 4'd8;
    localparam logic [3:0] OpEnd      = 4'd9;

    logic             clk;
    logic             rst_n;
    logic [NCH-1:0]   cmd_valid;
    logic [NCH-1:0]   cmd_ready;
    logic [NCH*CW-1:0] cmd_data;
    logic [NCH-1:0]   active_mask;
    logic [7:0]       sig_in;
    logic [7:0]       sig_out;
    logic [7:0]       flags;
    logic             ts_valid;
    logic [2:0]       ts_chan;
    logic [31:0]      ts_delta;
    logic             vector_done;
    logic [31:0]      vector_id;
    logic [31:0]      vector_count;
    logic             err;

    logic             tb_valid [NCH];
    logic [CW-1:0]    tb_data  [NCH];

    int checks = 0;
    int errors = 0;

    sonar_vector_sequencer dut (
        .ap_clk       (clk),
        .ap_rst_n     (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_data     (cmd_data),
        .active_mask  (active_mask),
        .sig_in       (sig_in),
        .sig_out      (sig_out),
        .flags        (flags),
        .ts_valid     (ts_valid),
        .ts_chan      (ts_chan),
        .ts_delta     (ts_delta),
        .vector_done  (vector_done),
        .vector_id    (vector_id),
        .vector_count (vector_count),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        cmd_valid = '0;
        cmd_data  = '0;
        for (int c = 0; c < NCH; c++) begin
            cmd_valid[c]         = tb_valid[c];
            cmd_data[c*CW +: CW] = tb_data[c];
        end
    end

    function automatic logic [CW-1:0] mk(input logic [3:0] op, input logic [3:0] sel,
                                          input logic [31:0] arg);
        return {op, sel, arg};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Present a command and return at the negedge after it is accepted; valid stays high.
    task automatic send(input int ch, input logic [3:0] op, input logic [3:0] sel,
                        input logic [31:0] arg);
        int n;
        n = 0;
        tb_data[ch]  = mk(op, sel, arg);
        tb_valid[ch] = 1'b1;
        #1;
        while (!cmd_ready[ch] && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL send_timeout ch=%0d actual=not_ready required=ready", ch);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int ch);
        tb_valid[ch] = 1'b0;
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [3:0]  sel;
        logic [31:0] arg;
        logic [7:0]  exp_sig;
        logic [7:0]  exp_flags;
        logic        exp_err;
    } vec_t;

    vec_t tbl [9];

    int hi, dn, dn_idx, r_idx, lv_idx;
    logic seen0;
    logic [31:0] cap_id, cap_cnt;

    initial begin
        tbl[0] = '{OpSignal,   4'd0, 32'd1, 8'h01, 8'h00, 1'b0};
        tbl[1] = '{OpSignal,   4'd7, 32'd1, 8'h81, 8'h00, 1'b0};
        tbl[2] = '{OpSignal,   4'd0, 32'd0, 8'h80, 8'h00, 1'b0};
        tbl[3] = '{OpFlagSet,  4'd0, 32'd5, 8'h80, 8'h20, 1'b0};
        tbl[4] = '{OpFlagSet,  4'd0, 32'd0, 8'h80, 8'h21, 1'b0};
        tbl[5] = '{OpFlagClr,  4'd0, 32'd5, 8'h80, 8'h01, 1'b0};
        tbl[6] = '{OpNop,      4'd0, 32'd0, 8'h80, 8'h01, 1'b0};
        tbl[7] = '{OpSignal,   4'd9, 32'd1, 8'h80, 8'h01, 1'b1};
        tbl[8] = '{OpFlagSet,  4'd0, 32'd8, 8'h80, 8'h01, 1'b1};

        for (int c = 0; c < NCH; c++) begin
            tb_valid[c] = 1'b0;
            tb_data[c]  = '0;
        end
        rst_n       = 1'b0;
        active_mask = '0;
        sig_in      = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_cmd_ready", 64'(cmd_ready), 64'h0);
        check("rst_sig_out", 64'(sig_out), 64'h0);
        check("rst_flags", 64'(flags), 64'h0);
        check("rst_ts_valid", 64'(ts_valid), 64'h0);
        check("rst_vector_done", 64'(vector_done), 64'h0);
        check("rst_vector_count", 64'(vector_count), 64'h0);
        check("rst_err", 64'(err), 64'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 64'(cmd_ready), 64'hf);

        // Single-cycle ops on ch0, effects visible the cycle after accept
        for (int i = 0; i < 9; i++) begin
            send(0, tbl[i].op, tbl[i].sel, tbl[i].arg);
            idle(0);
            check($sformatf("tbl%0d_sig", i), 64'(sig_out), 64'(tbl[i].exp_sig));
            check($sformatf("tbl%0d_flags", i), 64'(flags), 64'(tbl[i].exp_flags));
            check($sformatf("tbl%0d_err", i), 64'(err), 64'(tbl[i].exp_err));
        end

        rst_n = 1'b0;
        @(negedge clk);
        check("rst2_err", 64'(err), 64'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Pulse width from SIGNAL / DELAY 10 / SIGNAL, then single-channel barrier
        active_mask = 4'b0001;
        hi = 0;
        dn = 0;
        cap_id  = '0;
        cap_cnt = '0;
        fork
            begin
                send(0, OpSignal, 4'd2, 32'd1);
                send(0, OpDelay, 4'd0, 32'd10);
                send(0, OpSignal, 4'd2, 32'd0);
                send(0, OpEnd, 4'd0, 32'd7);
                idle(0);
            end
            begin
                for (int i = 0; i < 40; i++) begin
                    @(negedge clk);
                    if (sig_out[2]) hi++;
                    if (vector_done) begin
                        dn++;
                        cap_id  = vector_id;
                        cap_cnt = vector_count;
                    end
                end
            end
        join
        check("delay_pulse_width", 64'(hi), 64'd11);
        check("a_done_pulses", 64'(dn), 64'd1);
        check("a_vector_id", 64'(cap_id), 64'd7);
        check("a_vector_count", 64'(cap_cnt), 64'd1);

        // Flag handshake ch1 -> ch0 with a two-channel barrier
        active_mask = 4'b0011;
        dn = 0;
        dn_idx = -1;
        r_idx  = -1;
        lv_idx = -1;
        seen0  = 1'b0;
        fork
            begin
                send(0, OpWaitFlag, 4'd0, 32'd3);
                send(0, OpEnd, 4'd0, 32'd1);
                idle(0);
            end
            begin
                send(1, OpDelay, 4'd0, 32'd5);
                send(1, OpFlagSet, 4'd0, 32'd3);
                send(1, OpEnd, 4'd0, 32'd1);
                idle(1);
            end
            begin
                for (int i = 0; i < 40; i++) begin
                    @(negedge clk);
                    #1;
                    if (flags[3] && r_idx < 0) r_idx = i;
                    if (!cmd_ready[0]) seen0 = 1'b1;
                    else if (seen0 && lv_idx < 0) lv_idx = i;
                    if (vector_done) begin
                        dn++;
                        dn_idx  = i;
                        cap_id  = vector_id;
                        cap_cnt = vector_count;
                    end
                end
            end
        join
        check("wait_flag_release", 64'(lv_idx), 64'(r_idx + 1));
        check("b_done_pulses", 64'(dn), 64'd1);
        check("b_done_after_flag", 64'(dn_idx > r_idx + 1), 64'd1);
        check("b_vector_id", 64'(cap_id), 64'd1);
        check("b_vector_count", 64'(cap_cnt), 64'd2);
        active_mask = '0;
        @(negedge clk);

        // TIMESTAMP contention 20 cycles after TS_INIT
        tb_data[1]  = mk(OpTsInit, 4'd0, 32'd0);
        tb_valid[1] = 1'b1;
        @(negedge clk);
        tb_valid[1] = 1'b0;
        repeat (19) @(negedge clk);
        tb_data[1]  = mk(OpTs, 4'd0, 32'd0);
        tb_data[2]  = mk(OpTs, 4'd0, 32'd0);
        tb_valid[1] = 1'b1;
        tb_valid[2] = 1'b1;
        #1;
        check("ts_ready_ch1", 64'(cmd_ready[1]), 64'd1);
        check("ts_ready_ch2_lost", 64'(cmd_ready[2]), 64'd0);
        @(negedge clk);
        tb_valid[1] = 1'b0;
        check("ts1_valid", 64'(ts_valid), 64'd1);
        check("ts1_chan", 64'(ts_chan), 64'd1);
        check("ts1_delta", 64'(ts_delta), 64'd20);
        @(negedge clk);
        tb_valid[2] = 1'b0;
        check("ts2_valid", 64'(ts_valid), 64'd1);
        check("ts2_chan", 64'(ts_chan), 64'd2);
        check("ts2_delta", 64'(ts_delta), 64'd21);
        @(negedge clk);
        check("ts_strobe_drop", 64'(ts_valid), 64'd0);

        // Same-bit write conflicts: lowest channel wins
        send(3, OpFlagSet, 4'd0, 32'd1);
        idle(3);
        check("flag1_set", 64'(flags[1]), 64'd1);
        tb_data[0]  = mk(OpFlagClr, 4'd0, 32'd1);
        tb_data[3]  = mk(OpFlagSet, 4'd0, 32'd1);
        tb_valid[0] = 1'b1;
        tb_valid[3] = 1'b1;
        @(negedge clk);
        tb_valid[0] = 1'b0;
        tb_valid[3] = 1'b0;
        check("conflict_clr_wins", 64'(flags[1]), 64'd0);
        tb_data[1]  = mk(OpFlagSet, 4'd0, 32'd2);
        tb_data[2]  = mk(OpFlagClr, 4'd0, 32'd2);
        tb_valid[1] = 1'b1;
        tb_valid[2] = 1'b1;
        @(negedge clk);
        tb_valid[1] = 1'b0;
        tb_valid[2] = 1'b0;
        check("conflict_set_wins", 64'(flags[2]), 64'd1);

        // Unsatisfied WAIT abandoned by reset
        send(1, OpSignal, 4'd5, 32'd1);
        idle(1);
        check("sig5_set", 64'(sig_out), 64'h20);
        send(0, OpWait, 4'd4, 32'd1);
        idle(0);
        repeat (3) @(negedge clk);
        check("wait_stuck", 64'(cmd_ready[0]), 64'd0);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst3_ready", 64'(cmd_ready), 64'h0);
        check("rst3_sig_out", 64'(sig_out), 64'h0);
        check("rst3_flags", 64'(flags), 64'h0);
        check("rst3_vector_count", 64'(vector_count), 64'h0);
        check("rst3_ts_delta", 64'(ts_delta), 64'h0);
        check("rst3_vector_id", 64'(vector_id), 64'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst3_ch0_fetch", 64'(cmd_ready[0]), 64'd1);

        // Illegal opcode is sticky, following DELAY 3 still runs
        send(0, 4'd12, 4'd0, 32'd0);
        idle(0);
        check("illegal_err", 64'(err), 64'd1);
        send(0, OpDelay, 4'd0, 32'd3);
        idle(0);
        check("delay3_c1", 64'(cmd_ready[0]), 64'd0);
        @(negedge clk);
        check("delay3_c2", 64'(cmd_ready[0]), 64'd0);
        @(negedge clk);
        check("delay3_done", 64'(cmd_ready[0]), 64'd1);
        check("err_sticky", 64'(err), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
